// File: rtl/rem_result_display.sv
`default_nettype none
// ============================================================================
// Module      : rem_result_display
// Description : Captures the sign-magnitude result of the remainder unit
//               together with its zero / divide-by-zero flags and shows it on
//               a 4-digit multiplexed, active-low 7-segment display. A normal
//               result is shown as a signed decimal value (-15..15); a
//               divide-by-zero shows a blinking "Err".
// Ports       : clk        system clock, rising edge
//               rst        asynchronous active-high reset
//               valid      1-cycle capture strobe for result/zero/divbyzero
//               result     [4] sign, [3:0] magnitude
//               zero       remainder-is-zero flag (forces a displayed 0)
//               divbyzero  divide-by-zero flag (selects the Err display)
//               clear      synchronous return to the blank display
//               seg        segments {g,f,e,d,c,b,a}, active-low, registered
//               an         digit enables, active-low, an[0] rightmost, registered
//               loaded     high while a captured value or Err is held
// Revision    : 1.0 - initial release
// ============================================================================
module rem_result_display #(
    parameter int REFRESH_DIV = 4,
    parameter int BLINK_DIV   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [4:0] result,
    input  logic       zero,
    input  logic       divbyzero,
    input  logic       clear,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       loaded
);

    localparam int SCAN_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  c_SCAN_LAST  = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [SCAN_W-1:0]  c_SCAN_ONE   = SCAN_W'(1);
    localparam logic [BLINK_W-1:0] c_BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0] c_BLINK_ONE  = BLINK_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHOW  = 2'd1;
    localparam logic [1:0] c_ERROR = 2'd2;

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_MINUS = 7'b0111111;
    localparam logic [6:0] c_SEG_ONE   = 7'b1111001;
    localparam logic [6:0] c_SEG_E     = 7'b0000110;
    localparam logic [6:0] c_SEG_R     = 7'b0101111;

    // Decimal digit to active-low segment pattern; anything above 9 is blank.
    function automatic logic [6:0] f_digit_seg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = c_SEG_BLANK;
        endcase
        return pattern;
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_hold_load;
    logic               w_err_restart;
    logic [5:0]         r_hold;          // {sign, magnitude[3:0], zero}
    logic [SCAN_W-1:0]  r_scan;
    logic [1:0]         r_digit;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_off;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;
    logic [6:0]         w_seg_next;
    logic [3:0]         w_an_next;
    logic [3:0]         w_mag;
    logic               w_tens;
    logic [3:0]         w_units;
    logic               w_neg;
    logic [3:0]         w_digit_an;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: clear beats valid, so a strobe in a clear cycle
    // is discarded entirely.
    // ------------------------------------------------------------------
    always_comb begin
        w_hold_load   = 1'b0;
        w_err_restart = 1'b0;
        case (r_state)
            c_IDLE, c_SHOW, c_ERROR: w_state_next = r_state;
            default:                 w_state_next = c_IDLE;
        endcase
        if (clear) begin
            w_state_next = c_IDLE;
        end else if (valid) begin
            if (divbyzero) begin
                w_state_next  = c_ERROR;
                w_err_restart = 1'b1;
            end else begin
                w_state_next  = c_SHOW;
                w_hold_load   = 1'b1;
            end
        end
    end

    // Held result; an error capture leaves the previous value untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= 6'd0;
        end else if (w_hold_load) begin
            r_hold <= {result, zero};
        end
    end

    // Digit scan runs continuously, independent of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan  <= '0;
            r_digit <= 2'd0;
        end else if (r_scan == c_SCAN_LAST) begin
            r_scan  <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_scan  <= r_scan + c_SCAN_ONE;
        end
    end

    // Blink timer only advances while staying in ERROR; any other case
    // (including a fresh error capture) restarts it in the on-phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if ((r_state == c_ERROR) && (w_state_next == c_ERROR) && !w_err_restart) begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_BLINK_ONE;
            end
        end else begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: digit content from state, scan position and hold regs
    // ------------------------------------------------------------------
    // The zero flag overrides whatever magnitude came with it.
    assign w_mag      = r_hold[0] ? 4'd0 : r_hold[4:1];
    assign w_tens     = (w_mag >= 4'd10);
    assign w_units    = w_tens ? (w_mag - 4'd10) : w_mag;
    assign w_neg      = r_hold[5] && (w_mag != 4'd0);
    assign w_digit_an = ~(4'b0001 << r_digit);

    always_comb begin
        w_seg_next = c_SEG_BLANK;
        w_an_next  = 4'b1111;
        case (r_state)
            c_SHOW: begin
                w_an_next = w_digit_an;
                case (r_digit)
                    2'd0:    w_seg_next = f_digit_seg(w_units);
                    2'd1:    w_seg_next = w_tens ? c_SEG_ONE : c_SEG_BLANK;
                    2'd2:    w_seg_next = w_neg ? c_SEG_MINUS : c_SEG_BLANK;
                    default: w_seg_next = c_SEG_BLANK;
                endcase
            end
            c_ERROR: begin
                if (!r_blink_off) begin
                    w_an_next = w_digit_an;
                    case (r_digit)
                        2'd1, 2'd2: w_seg_next = c_SEG_R;
                        2'd3:       w_seg_next = c_SEG_E;
                        default:    w_seg_next = c_SEG_BLANK;
                    endcase
                end
            end
            default: begin
                w_seg_next = c_SEG_BLANK;
                w_an_next  = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= c_SEG_BLANK;
            r_an  <= 4'b1111;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign seg    = r_seg;
    assign an     = r_an;
    assign loaded = (r_state == c_SHOW) || (r_state == c_ERROR);

endmodule
`default_nettype wire
